// File: rtl/text_cursor_ctrl_if.sv
// Keyboard-side handshake plus character-RAM write port of the text cursor
// controller, bundled as one interface.
//   master : keyboard/host side (drives ascii, ascii_valid, clear_req)
//   slave  : text_cursor_ctrl (drives ready/busy, RAM write port, cursor)
// Signals:
//   ascii[7:0], ascii_valid, ascii_ready  byte handshake
//   clear_req, busy                       screen clear request / in progress
//   ram_we, ram_addr[AW-1:0], ram_wdata   char RAM write port
//   cur_x[XW-1:0], cur_y[YW-1:0]          cursor position
//   cursor_on                             cursor blink phase
interface text_cursor_ctrl_if #(
    parameter int XW = 7,
    parameter int YW = 5,
    parameter int AW = 12
);
    logic [7:0]    ascii;
    logic          ascii_valid;
    logic          ascii_ready;
    logic          clear_req;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          cursor_on;

    modport master (
        output ascii, ascii_valid, clear_req,
        input  ascii_ready, busy, ram_we, ram_addr, ram_wdata,
               cur_x, cur_y, cursor_on
    );

    modport slave (
        input  ascii, ascii_valid, clear_req,
        output ascii_ready, busy, ram_we, ram_addr, ram_wdata,
               cur_x, cur_y, cursor_on
    );
endinterface

// File: rtl/text_cursor_ctrl.sv
// Write sequencer for the character-tile RAM of the text display.
// Accepts ASCII bytes over a valid/ready handshake, tracks the cursor,
// handles CR / BS / wrap, runs a full-screen clear and a blink phase.
// Ports:
//   clk  pixel clock
//   rst  asynchronous active-high reset
//   bus  text_cursor_ctrl_if.slave (handshake, RAM write port, cursor)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting bytes, one RAM write per accepted printable/BS
// CLEAR | writing 0x20 to every cell, one per cycle; bytes held off
module text_cursor_ctrl #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int XW           = 7,
    parameter int YW           = 5,
    parameter int AW           = 12,
    parameter int BLINK_CYC    = 12500000,
    parameter int CLEAR_ON_RST = 1
) (
    input logic               clk,
    input logic               rst,
    text_cursor_ctrl_if.slave bus
);

    localparam int NCELL = COLS * ROWS;
    localparam int BW    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : IDLE;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [BW-1:0] blink_cnt;
    logic          accept;

    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [7:0]    wr_data;
    logic          do_wr;
    logic          last_col;
    logic          last_row;

    assign bus.ascii_ready = (state == IDLE) && !bus.clear_req;
    assign bus.busy        = (state == CLEAR);
    assign accept          = bus.ascii_valid && bus.ascii_ready;

    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                                input logic [YW-1:0] y);
        return AW'(y) * AW'(COLS) + AW'(x);
    endfunction

    // Decode of the byte currently offered: where the cursor goes and
    // whether (and where) a cell gets written if the byte is accepted.
    always_comb begin
        nxt_x    = bus.cur_x;
        nxt_y    = bus.cur_y;
        wr_x     = bus.cur_x;
        wr_y     = bus.cur_y;
        wr_data  = bus.ascii;
        do_wr    = 1'b0;
        last_col = (bus.cur_x == XW'(COLS - 1));
        last_row = (bus.cur_y == YW'(ROWS - 1));
        if (bus.ascii >= 8'h20 && bus.ascii <= 8'h7E) begin
            do_wr = 1'b1;
            if (last_col) begin
                nxt_x = '0;
                nxt_y = last_row ? '0 : bus.cur_y + YW'(1);
            end else begin
                nxt_x = bus.cur_x + XW'(1);
            end
        end else if (bus.ascii == 8'h0D) begin
            nxt_x = '0;
            nxt_y = last_row ? '0 : bus.cur_y + YW'(1);
        end else if (bus.ascii == 8'h08) begin
            wr_data = 8'h20;
            if (bus.cur_x != '0) begin
                nxt_x = bus.cur_x - XW'(1);
                wr_x  = bus.cur_x - XW'(1);
                do_wr = 1'b1;
            end else if (bus.cur_y != '0) begin
                nxt_x = XW'(COLS - 1);
                nxt_y = bus.cur_y - YW'(1);
                wr_x  = XW'(COLS - 1);
                wr_y  = bus.cur_y - YW'(1);
                do_wr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RST_STATE;
            clr_cnt       <= '0;
            blink_cnt     <= '0;
            bus.cursor_on <= 1'b1;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.cur_x     <= '0;
            bus.cur_y     <= '0;
        end else begin
            bus.ram_we <= 1'b0;

            // Typing restarts the blink so the cursor is visible while typing.
            if (accept) begin
                blink_cnt     <= '0;
                bus.cursor_on <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_CYC - 1)) begin
                blink_cnt     <= '0;
                bus.cursor_on <= ~bus.cursor_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (accept) begin
                        bus.cur_x <= nxt_x;
                        bus.cur_y <= nxt_y;
                        if (do_wr) begin
                            bus.ram_we    <= 1'b1;
                            bus.ram_addr  <= cell_addr(wr_x, wr_y);
                            bus.ram_wdata <= wr_data;
                        end
                    end
                end
                CLEAR: begin
                    bus.ram_we    <= 1'b1;
                    bus.ram_addr  <= clr_cnt;
                    bus.ram_wdata <= 8'h20;
                    if (clr_cnt == AW'(NCELL - 1)) begin
                        clr_cnt   <= '0;
                        state     <= IDLE;
                        bus.cur_x <= '0;
                        bus.cur_y <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Self-checking bench for text_cursor_ctrl (80x30 screen, BLINK_CYC=4,
// clear after reset). A linear-position screen model predicts outputs
// every cycle; directed steps add hand-computed literal expectations.
module tb_text_cursor_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int XW    = 7;
    localparam int YW    = 5;
    localparam int AW    = 12;
    localparam int BLINK = 4;
    localparam int NCELL = COLS * ROWS;

    logic clk;
    logic rst;

    text_cursor_ctrl_if #(.XW(XW), .YW(YW), .AW(AW)) bus ();

    text_cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .AW(AW),
        .BLINK_CYC(BLINK), .CLEAR_ON_RST(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int wr_total = 0;

    // Screen model: cursor kept as a linear cell index, blink phase derived
    // from the number of edges since the last accept/reset.
    int   m_pos;
    bit   m_busy;
    int   m_idx;
    bit   m_we;
    int   m_addr;
    int   m_data;
    int   m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  = 0;
            m_busy = 1;
            m_idx  = 0;
            m_we   = 0;
            m_addr = 0;
            m_data = 0;
            m_k    = 0;
        end else begin
            m_we = 0;
            if (m_busy) begin
                m_we   = 1;
                m_addr = m_idx;
                m_data = 32;
                m_idx  = m_idx + 1;
                if (m_idx == NCELL) begin
                    m_busy = 0;
                    m_pos  = 0;
                end
                m_k = m_k + 1;
            end else if (bus.clear_req) begin
                m_busy = 1;
                m_idx  = 0;
                m_k    = m_k + 1;
            end else if (bus.ascii_valid) begin
                m_k = 0;
                if (bus.ascii >= 8'd32 && bus.ascii <= 8'd126) begin
                    m_we   = 1;
                    m_addr = m_pos;
                    m_data = int'(bus.ascii);
                    m_pos  = (m_pos + 1) % NCELL;
                end else if (bus.ascii == 8'd13) begin
                    m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
                end else if (bus.ascii == 8'd8 && m_pos > 0) begin
                    m_pos  = m_pos - 1;
                    m_we   = 1;
                    m_addr = m_pos;
                    m_data = 32;
                end
            end else begin
                m_k = m_k + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model_we", int'(bus.ram_we), int'(m_we));
            if (m_we) begin
                check("model_addr", int'(bus.ram_addr), m_addr);
                check("model_wdata", int'(bus.ram_wdata), m_data);
            end
            check("model_cur_x", int'(bus.cur_x), m_pos % COLS);
            check("model_cur_y", int'(bus.cur_y), m_pos / COLS);
            check("model_busy", int'(bus.busy), int'(m_busy));
            check("model_ready", int'(bus.ascii_ready),
                  int'(!m_busy && !bus.clear_req));
            check("model_cursor_on", int'(bus.cursor_on),
                  int'(((m_k / BLINK) % 2) == 0));
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.ram_we) wr_total++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        bus.ascii       = b;
        bus.ascii_valid = 1'b1;
        n = 0;
        while (!bus.ascii_ready && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.ascii_valid = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] b, input int cnt);
        for (int i = 0; i < cnt; i++) send(b);
    endtask

    int cyc;
    int base;

    initial begin
        rst             = 1'b1;
        bus.ascii       = 8'h00;
        bus.ascii_valid = 1'b0;
        bus.clear_req   = 1'b0;
        #1;
        check("rst_we", int'(bus.ram_we), 0);
        check("rst_addr", int'(bus.ram_addr), 0);
        check("rst_wdata", int'(bus.ram_wdata), 0);
        check("rst_cur_x", int'(bus.cur_x), 0);
        check("rst_cursor_on", int'(bus.cursor_on), 1);
        check("rst_busy", int'(bus.busy), 1);
        step();
        step();
        rst  = 1'b0;
        base = wr_total;

        // Power-up clear
        cyc = 0;
        while (bus.busy && cyc < 5000) begin
            step();
            cyc++;
        end
        check("clear_busy_cycles", cyc, NCELL);
        check("clear_ready_after", int'(bus.ascii_ready), 1);
        check("clear_last_addr", int'(bus.ram_addr), NCELL - 1);
        check("clear_last_data", int'(bus.ram_wdata), 32);
        step();
        check("clear_write_count", wr_total - base, NCELL);

        // 'A','B' back to back
        send(8'h41);
        check("a_we", int'(bus.ram_we), 1);
        check("a_addr", int'(bus.ram_addr), 0);
        check("a_data", int'(bus.ram_wdata), 8'h41);
        send(8'h42);
        check("b_addr", int'(bus.ram_addr), 1);
        check("b_data", int'(bus.ram_wdata), 8'h42);
        check("b_cur_x", int'(bus.cur_x), 2);
        check("b_cur_y", int'(bus.cur_y), 0);

        // Screen wrap at the last cell
        send_n(8'h0D, 29);
        send_n(8'h61, 79);
        check("pre_z_cur_x", int'(bus.cur_x), 79);
        check("pre_z_cur_y", int'(bus.cur_y), 29);
        send(8'h5A);
        check("z_addr", int'(bus.ram_addr), 2399);
        check("z_data", int'(bus.ram_wdata), 8'h5A);
        check("z_cur_x", int'(bus.cur_x), 0);
        check("z_cur_y", int'(bus.cur_y), 0);

        // CR on the last row
        send_n(8'h0D, 29);
        send_n(8'h62, 5);
        send(8'h0D);
        check("cr_we", int'(bus.ram_we), 0);
        check("cr_cur_x", int'(bus.cur_x), 0);
        check("cr_cur_y", int'(bus.cur_y), 0);

        // Backspace across a row boundary and at home
        send(8'h0D);
        send(8'h08);
        check("bs_we", int'(bus.ram_we), 1);
        check("bs_addr", int'(bus.ram_addr), 79);
        check("bs_data", int'(bus.ram_wdata), 32);
        check("bs_cur_x", int'(bus.cur_x), 79);
        check("bs_cur_y", int'(bus.cur_y), 0);
        send_n(8'h0D, 30);
        send(8'h08);
        check("bs_home_we", int'(bus.ram_we), 0);
        check("bs_home_cur_x", int'(bus.cur_x), 0);
        check("bs_home_cur_y", int'(bus.cur_y), 0);

        // Clear wins over a simultaneous byte; byte held until clear ends
        bus.clear_req   = 1'b1;
        bus.ascii       = 8'h41;
        bus.ascii_valid = 1'b1;
        #1;
        check("clr_vs_byte_ready", int'(bus.ascii_ready), 0);
        step();
        bus.clear_req = 1'b0;
        check("clr_started", int'(bus.busy), 1);
        base = wr_total;
        cyc  = 0;
        while (!bus.ascii_ready && cyc < 5000) begin
            step();
            cyc++;
            if (cyc == 100) bus.clear_req = 1'b1;
            if (cyc == 101) bus.clear_req = 1'b0;
        end
        check("clr2_busy_cycles", cyc, NCELL);
        @(posedge clk);
        #1;
        bus.ascii_valid = 1'b0;
        check("clr2_write_count", wr_total - base, NCELL);
        check("held_a_addr", int'(bus.ram_addr), 0);
        check("held_a_data", int'(bus.ram_wdata), 8'h41);
        check("held_a_cur_x", int'(bus.cur_x), 1);

        // Blink phase: 4 cycles on, 4 off, restarted by an accept
        check("blink_k0", int'(bus.cursor_on), 1);
        step(); step(); step();
        check("blink_k3", int'(bus.cursor_on), 1);
        step();
        check("blink_k4", int'(bus.cursor_on), 0);
        step(); step(); step(); step();
        check("blink_k8", int'(bus.cursor_on), 1);
        step(); step(); step(); step(); step();
        check("blink_k13", int'(bus.cursor_on), 0);
        send(8'h78);
        check("blink_restart", int'(bus.cursor_on), 1);
        check("x_cur_x", int'(bus.cur_x), 2);

        // Reset in the middle of a clear
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        repeat (50) step();
        #5;
        rst = 1'b1;
        #1;
        check("midrst_we", int'(bus.ram_we), 0);
        check("midrst_addr", int'(bus.ram_addr), 0);
        check("midrst_cur_x", int'(bus.cur_x), 0);
        check("midrst_cursor_on", int'(bus.cursor_on), 1);
        check("midrst_busy", int'(bus.busy), 1);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = wr_total;
        step();
        check("restart_we", int'(bus.ram_we), 1);
        check("restart_addr", int'(bus.ram_addr), 0);
        cyc = 1;
        while (bus.busy && cyc < 5000) begin
            step();
            cyc++;
        end
        check("restart_busy_cycles", cyc, NCELL);
        step();
        check("restart_write_count", wr_total - base, NCELL);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
